// File: rtl/quad_gen_pkg.sv
// Shared types and Gray-phase helpers for the quadrature encoder generator.
package quad_gen_pkg;

  localparam int unsigned PH_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Phase encoding is {a, b}; forward walks PH0->PH1->PH2->PH3->PH0.
  localparam logic [PH_W-1:0] PH0 = 2'b00;
  localparam logic [PH_W-1:0] PH1 = 2'b10;
  localparam logic [PH_W-1:0] PH2 = 2'b11;
  localparam logic [PH_W-1:0] PH3 = 2'b01;

  function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] ph);
    logic [PH_W-1:0] r;
    case (ph)
      PH0:     r = PH1;
      PH1:     r = PH2;
      PH2:     r = PH3;
      default: r = PH0;
    endcase
    return r;
  endfunction

  function automatic logic [PH_W-1:0] prev_phase(input logic [PH_W-1:0] ph);
    logic [PH_W-1:0] r;
    case (ph)
      PH0:     r = PH3;
      PH3:     r = PH2;
      PH2:     r = PH1;
      default: r = PH0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_tick_timer.sv
// Reloading down-counter: tick_c_o fires every period cycles while enabled.
module quad_tick_timer
  import quad_gen_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_c_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] reload_q, reload_d;
  logic [PERIOD_W-1:0] eff_period;

  // A zero period would never tick; treat it as one.
  assign eff_period = (period_i == '0) ? PERIOD_W'(1) : period_i;
  assign tick_c_o   = en_i && (cnt_q == PERIOD_W'(1));

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (load_i) begin
      cnt_d    = eff_period;
      reload_d = eff_period;
    end else if (en_i) begin
      cnt_d = (cnt_q == PERIOD_W'(1)) ? reload_q : cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B transmitter: steps a Gray phase N times, P clocks apart, per command.
module quad_encoder_gen
  import quad_gen_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned POS_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] phase_period,
  input  logic                abort,
  output logic                enc_a,
  output logic                enc_b,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  steps_left,
  output logic [POS_W-1:0]    position
);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              dir_q, dir_d;
  logic [COUNT_W-1:0] steps_q, steps_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              done_q, done_d;
  logic              load_c;
  logic              tick_c;

  quad_tick_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load_c),
    .en_i    (state_q == RUN),
    .period_i(phase_period),
    .tick_c_o(tick_c)
  );

  // Next-state: a tick and an abort on the same edge still emit the transition.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          steps_d = cmd_steps;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            load_c  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (tick_c) begin
          phase_d = dir_q ? next_phase(phase_q) : prev_phase(phase_q);
          pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          steps_d = steps_q - COUNT_W'(1);
          if (steps_q == COUNT_W'(1) || abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= PH0;
      dir_q   <= 1'b0;
      steps_q <= '0;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign enc_a      = phase_q[1];
  assign enc_b      = phase_q[0];
  assign done       = done_q;
  assign steps_left = steps_q;
  assign position   = pos_q;

endmodule
